seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clock cycles each digit is driven (SHOW dwell).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500, giving the all-anodes-off cycles between digits (anti-ghosting).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, where high = scan display and low = display off.
REQ-006 The block SHALL have port value, input, 16, four BCD digits with digit 0 at [3:0] and digit 3 at [15:12].
REQ-007 The block SHALL have port load, input, 1, a strobe that captures value into the pending register.
REQ-008 The block SHALL have port bcd_out, input-to-decoder output, 4, the nibble for the downstream BCD-to-7-segment decoder; 4'hF = blank.
REQ-009 The block SHALL have port anodes, output, 4, active-low digit enables where bit n = digit n.
REQ-010 The block SHALL have port frame_tick, output, 1, a one-cycle pulse on each pending-to-display transfer.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 The FSM SHALL have states IDLE, SHOW and BLANK, plus a 2-bit digit index, a dwell counter and two 16-bit registers, pending and display.
REQ-013 In IDLE, the block SHALL drive anodes=4'b1111 and bcd_out=4'hF; when enable=1, it SHALL move to SHOW with index 0 on the next edge.
REQ-014 In SHOW, the block SHALL drive anodes with only bit [index] low and bcd_out=display nibble [index]; after exactly REFRESH_DIV cycles it SHALL move to BLANK.
REQ-015 In BLANK, the block SHALL drive anodes=4'b1111 and bcd_out=4'hF; after exactly BLANK_CYCLES cycles it SHALL move to SHOW with index+1, wrapping 3 to 0.
REQ-016 If BLANK_CYCLES=0, BLANK SHALL be skipped and SHOW SHALL advance directly to the next digit.
REQ-017 A load=1 cycle SHALL write value to pending; a later load SHALL overwrite an earlier one.
REQ-018 On every entry to SHOW with index 0 (from IDLE or from wrap-around), pending SHALL be copied to display and frame_tick SHALL be 1 in that first SHOW cycle; otherwise frame_tick SHALL be 0.
REQ-019 bcd_out in that first SHOW cycle SHALL already reflect the newly transferred value, so no digit tears within a frame.
REQ-020 If load and transfer coincide, the value on the value port that cycle SHALL be transferred (bypass).
REQ-021 Nibbles 4'hA to 4'hF SHALL pass through unchanged; blanking them is the decoder's job.
REQ-022 If enable drops in any state, the next edge SHALL enter IDLE with index=0 and counter=0; pending SHALL be retained.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set state=IDLE, index=0, counter=0, pending=0, display=0, anodes=4'b1111, bcd_out=4'hF and frame_tick=0.
REQ-024 Reset SHALL take priority over enable and load, including mid-SHOW and mid-BLANK.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, in SHOW for index n>0, bcd_out SHALL be 4'hF, with the anode still driven, whenever display digits n..3 are all 4'h0.
REQ-026 Digit 0 SHALL never be blanked by the LEADING_ZERO_BLANK_EN feature.
REQ-027 When LEADING_ZERO_BLANK_EN is undefined, all digits SHALL display as stored.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-028 Apply rst, then enable=1, load=1 with value=16'h1234 -> frame_tick pulses once; anodes/bcd_out sequence 1110/4 for 4 cycles, 1111/F for 2 cycles, 1101/3, 1011/2, 0111/1; the frame repeats every 24 cycles.
REQ-029 load=1 with value=16'h5678 mid-frame at digit 2 -> digits 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5 with a frame_tick at its start.
REQ-030 Assert rst during BLANK after digit 1 -> the next cycle gives anodes=1111, bcd_out=F, frame_tick=0 and display=0; with enable=1 the next frame shows 0000.
REQ-031 Drop enable for 1 cycle during SHOW digit 2 -> IDLE outputs; on re-enable the scan restarts at digit 0 with frame_tick and the earlier pending value.
REQ-032 With LEADING_ZERO_BLANK_EN defined and value=16'h0040 -> digit 3 gives bcd_out F with anode 0111, digit 2 gives F, digit 1 gives 4, digit 0 gives 0; undefined -> 0, 0, 4, 0.
REQ-033 With value=16'h00AF -> bcd_out shows F and A unchanged on digits 0 and 1.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed BCD display scanner with SHOW/BLANK dwell and frame-synchronous update.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic [3:0]  anodes,
    output logic        frame_tick
);

    localparam int unsigned MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [15:0]     r_pending, r_display;
    logic [15:0]     w_pend_nxt, w_disp_nxt;
    logic            w_xfer;
    logic [3:0]      w_anodes_nxt, w_bcd_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = S_SHOW;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_cnt_nxt = '0;
                    if (BLANK_CYCLES == 0) begin
                        w_idx_nxt = r_idx + 2'd1;
                    end else begin
                        w_state_nxt = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHOW;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 2'd0;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end

        // Transfer on any fresh entry to digit 0; load in the same cycle bypasses pending.
        w_xfer     = (w_state_nxt == S_SHOW) && (w_idx_nxt == 2'd0) &&
                     !((r_state == S_SHOW) && (r_idx == 2'd0));
        w_pend_nxt = load ? value : r_pending;
        w_disp_nxt = w_xfer ? w_pend_nxt : r_display;

        w_anodes_nxt = 4'b1111;
        w_bcd_nxt    = 4'hF;
        if (w_state_nxt == S_SHOW) begin
            w_anodes_nxt = ~(4'b0001 << w_idx_nxt);
            w_bcd_nxt    = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if ((w_idx_nxt != 2'd0) && ((w_disp_nxt >> {w_idx_nxt, 2'b00}) == 16'h0000)) begin
                w_bcd_nxt = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_display  <= '0;
            anodes     <= 4'b1111;
            bcd_out    <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pending  <= w_pend_nxt;
            r_display  <= w_disp_nxt;
            anodes     <= w_anodes_nxt;
            bcd_out    <= w_bcd_nxt;
            frame_tick <= w_xfer;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
// Expected {anodes, bcd_out, frame_tick} is queued when inputs are driven and checked after the edge.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  anodes;
    logic        frame_tick;

    int unsigned n_tests = 0;
    int unsigned n_fails = 0;
    int unsigned n_cyc   = 0;
    logic [8:0]  exp_q[$];

    seven_seg_scanner #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .bcd_out   (bcd_out),
        .anodes    (anodes),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got an=%b bcd=%h tick=%b, expected an=%b bcd=%h tick=%b",
                     tag, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // Monitor: one expected entry per clock edge following a driven cycle.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d", n_cyc), {anodes, bcd_out, frame_tick}, e);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic l, input logic [15:0] v,
                       input logic [8:0] exp);
        @(negedge clk);
        rst    = r;
        enable = e;
        load   = l;
        value  = v;
        exp_q.push_back(exp);
    endtask

    function automatic logic [3:0] exp_nib(input logic [15:0] shown, input int d);
        logic [15:0] s;
        s = shown;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (s >> (4 * d)) == 16'h0000) return 4'hF;
`endif
        return s[4*d +: 4];
    endfunction

    // Drive ncyc cycles of a scanning frame with enable high; optional load at cycle ld_cyc.
    task automatic frame(input logic [15:0] shown, input int ncyc, input int ld_cyc,
                         input logic [15:0] ld_val);
        for (int c = 0; c < ncyc; c++) begin
            int d, p;
            logic [3:0] an;
            logic [8:0] ex;
            d  = c / 6;
            p  = c % 6;
            an = 4'b1111;
            if (p < 4) begin
                an[d] = 1'b0;
                ex = {an, exp_nib(shown, d), (c == 0)};
            end else begin
                ex = {4'b1111, 4'hF, 1'b0};
            end
            cyc(1'b0, 1'b1, (c == ld_cyc), (c == ld_cyc) ? ld_val : 16'hDEAD, ex);
        end
    endtask

    localparam logic [8:0] OFF = {4'b1111, 4'hF, 1'b0};

    initial begin
        int unsigned guard;
        // Reset, then idle with enable low
        cyc(1'b1, 1'b0, 1'b0, 16'h0, OFF);
        cyc(1'b1, 1'b1, 1'b1, 16'h9999, OFF);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, OFF);
        // Load coinciding with first transfer (bypass), frame repeats
        frame(16'h1234, 24, 0, 16'h1234);
        frame(16'h1234, 24, -1, 16'h0);
        // Mid-frame load at digit 2 does not tear the current frame
        frame(16'h1234, 24, 12, 16'h5678);
        frame(16'h5678, 24, -1, 16'h0);
        // Reset during BLANK after digit 1, then a 0000 frame
        frame(16'h5678, 11, -1, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, OFF);
        frame(16'h0000, 24, -1, 16'h0);
        // Pending update, then enable drop during digit 2 restarts at digit 0
        frame(16'h0000, 13, 3, 16'h4321);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, OFF);
        frame(16'h4321, 24, -1, 16'h0);
        // Leading zeros and pass-through of A..F nibbles
        frame(16'h0040, 24, 0, 16'h0040);
        frame(16'h00AF, 24, 0, 16'h00AF);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, OFF);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, OFF);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
